// File: rtl/uart_rx_loader.sv
// uart_rx_loader: UART receiver that writes each good 8N1 byte into the image
// RAM at an incrementing address and flags rx_finish once NUM_BYTES bytes have
// been stored. Optional even-parity framing (8E1) is enabled by defining
// UART_RX_EVEN_PARITY_EN; without it the frame is 8N1 and parity_err is 0.
module uart_rx_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 18,
    parameter int NUM_BYTES    = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rx_finish,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [ADDR_W:0]   COUNT_END = (ADDR_W + 1)'(NUM_BYTES);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH, S_WRITE, S_DONE
    } state_e;

    state_e            state_q;
    logic              rx_meta_q;
    logic              rxs_q;
    logic [TICK_W-1:0] tick_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_inc;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              rx_finish_q;
    logic              frame_err_q;

    assign count_inc = count_q + COUNT_ONE;

    // Two-flop synchroniser for the asynchronous rx pin; idles high out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

`ifdef UART_RX_EVEN_PARITY_EN
    logic parity_err_q;
    logic par_bad_q;
`endif

    // Receive FSM: start/data/stop sampling, RAM write strobe and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            count_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rx_finish_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_EVEN_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= S_START;
                        tick_q  <= '0;
                    end
                end
                S_START: begin
                    // Re-check the line half a bit in so short glitches are ignored.
                    if (tick_q == TICK_HALF) begin
                        tick_q  <= '0;
                        bit_q   <= '0;
                        state_q <= rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_q <= tick_q + TICK_ONE;
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q  <= '0;
                        shift_q <= {rxs_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_EVEN_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        tick_q <= tick_q + TICK_ONE;
                    end
                end
`ifdef UART_RX_EVEN_PARITY_EN
                S_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q  <= '0;
                        state_q <= S_STOP;
                        if (rxs_q != ^shift_q) begin
                            parity_err_q <= 1'b1;
                            par_bad_q    <= 1'b1;
                        end else begin
                            par_bad_q <= 1'b0;
                        end
                    end else begin
                        tick_q <= tick_q + TICK_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (!rxs_q) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_HIGH;
`ifdef UART_RX_EVEN_PARITY_EN
                        end else if (par_bad_q) begin
                            state_q <= S_IDLE;
`endif
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= shift_q;
                            wr_addr_q <= count_q[ADDR_W-1:0];
                            state_q   <= S_WRITE;
                        end
                    end else begin
                        tick_q <= tick_q + TICK_ONE;
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line (break) must return high before a new start bit counts.
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    wr_en_q <= 1'b0;
                    count_q <= count_inc;
                    if (count_inc == COUNT_END) begin
                        rx_finish_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (!rxs_q) begin
                        // Start bit may already be present when the stop bit is one bit long.
                        state_q <= S_START;
                        tick_q  <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rx_finish = rx_finish_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_EVEN_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
